// File: rtl/cpu_pkg.sv
// Shared definitions for the MCS8 core pipeline: register indices,
// result-select bit positions, the W-stage bundle and small helpers.
package cpu_pkg;

  localparam int DATA_W    = 8;
  localparam int REG_IDX_W = 3;
  localparam int SEL_W     = 4;

  localparam logic [REG_IDX_W-1:0] REG_A = 3'd0;
  localparam logic [REG_IDX_W-1:0] REG_B = 3'd1;
  localparam logic [REG_IDX_W-1:0] REG_C = 3'd2;
  localparam logic [REG_IDX_W-1:0] REG_D = 3'd3;
  localparam logic [REG_IDX_W-1:0] REG_E = 3'd4;
  localparam logic [REG_IDX_W-1:0] REG_H = 3'd5;
  localparam logic [REG_IDX_W-1:0] REG_L = 3'd6;
  localparam logic [REG_IDX_W-1:0] REG_M = 3'd7;

  localparam int SEL_C = 0;
  localparam int SEL_S = 1;
  localparam int SEL_E = 2;
  localparam int SEL_M = 3;

  typedef struct packed {
    logic                 valid;
    logic                 dstr_cs;
    logic [SEL_W-1:0]     sel;
    logic [REG_IDX_W-1:0] dst;
    logic [DATA_W-1:0]    val_c;
    logic [DATA_W-1:0]    val_s;
    logic [DATA_W-1:0]    val_e;
    logic [DATA_W-1:0]    val_m;
  } wb_bundle_t;

  function automatic logic sel_onehot(input logic [SEL_W-1:0] sel);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < SEL_W; i++) begin
      if (sel[i]) ones++;
    end
    return (ones == 1);
  endfunction

  // Priority M > E > S > C so a malformed select still writes something predictable.
  function automatic logic [DATA_W-1:0] sel_mux(
    input logic [SEL_W-1:0]  sel,
    input logic [DATA_W-1:0] val_c,
    input logic [DATA_W-1:0] val_s,
    input logic [DATA_W-1:0] val_e,
    input logic [DATA_W-1:0] val_m
  );
    if (sel[SEL_M])      return val_m;
    else if (sel[SEL_E]) return val_e;
    else if (sel[SEL_S]) return val_s;
    else                 return val_c;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Architectural register file: one asynchronous read port and one
// synchronous write port. Indices at or above REG_NUM read as zero and
// are never written.
import cpu_pkg::*;

module cpu_regfile #(
  parameter int REG_NUM = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_idx,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [REG_IDX_W-1:0] rd_idx,
  output logic [DATA_W-1:0]    rd_data
);

  logic [DATA_W-1:0] regs [REG_NUM];

  // Storage update: clear on reset, otherwise write the addressed entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (wr_idx == REG_IDX_W'(i)) regs[i] <= wr_data;
      end
    end
  end

  // Read decode; no bypass of a same-cycle write.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (rd_idx == REG_IDX_W'(i)) rd_data = regs[i];
    end
  end

endmodule

// File: rtl/cpu_writeback.sv
// Write-back stage of the MCS8 core: W pipeline register, result select,
// register-file commit, retire counter and sticky select-error flag.
import cpu_pkg::*;

module cpu_writeback #(
  parameter int REG_NUM = 7,
  parameter int CNT_W   = 16
) (
  input  logic                 CLK_I,
  input  logic                 RSTN_I,
  input  logic                 STALL_I,
  input  logic                 BUBBLE_I,
  input  logic [DATA_W-1:0]    M_VAL_C_I,
  input  logic [DATA_W-1:0]    M_VAL_S_I,
  input  logic [DATA_W-1:0]    M_VAL_E_I,
  input  logic [DATA_W-1:0]    M_VAL_M_I,
  input  logic [REG_IDX_W-1:0] M_DST_I,
  input  logic                 M_VALID_I,
  input  logic                 M_DSTR_CS_I,
  input  logic                 M_DSTR_CS_C_I,
  input  logic                 M_DSTR_CS_S_I,
  input  logic                 M_DSTR_CS_E_I,
  input  logic                 M_DSTR_CS_M_I,
  output logic [DATA_W-1:0]    W_VAL_C_O,
  output logic [DATA_W-1:0]    W_VAL_S_O,
  output logic [DATA_W-1:0]    W_VAL_E_O,
  output logic [DATA_W-1:0]    W_VAL_M_O,
  output logic [REG_IDX_W-1:0] W_DST_O,
  output logic                 W_VALID_O,
  output logic                 W_DSTR_CS_O,
  output logic                 W_DSTR_CS_C_O,
  output logic                 W_DSTR_CS_S_O,
  output logic                 W_DSTR_CS_E_O,
  output logic                 W_DSTR_CS_M_O,
  input  logic [REG_IDX_W-1:0] REG_SRC_I,
  output logic [DATA_W-1:0]    REG_BANK_O,
  output logic [CNT_W-1:0]     RETIRE_CNT_O,
  output logic                 SEL_ERR_O
);

  wb_bundle_t        w_q;
  wb_bundle_t        w_d;
  logic              load_valid;
  logic              commit;
  logic              wr_target;
  logic              wr_en;
  logic              sel_bad;
  logic [DATA_W-1:0] wr_data;
  logic [CNT_W-1:0]  retire_cnt;
  logic              sel_err;

  // Next W bundle: hold on stall, otherwise load M with control squashed for empty slots.
  always_comb begin
    w_d        = w_q;
    load_valid = M_VALID_I & ~BUBBLE_I;
    if (!STALL_I) begin
      w_d.valid        = load_valid;
      w_d.dstr_cs      = M_DSTR_CS_I & load_valid;
      w_d.sel[SEL_C]   = M_DSTR_CS_C_I & load_valid;
      w_d.sel[SEL_S]   = M_DSTR_CS_S_I & load_valid;
      w_d.sel[SEL_E]   = M_DSTR_CS_E_I & load_valid;
      w_d.sel[SEL_M]   = M_DSTR_CS_M_I & load_valid;
      w_d.dst          = M_DST_I;
      w_d.val_c        = M_VAL_C_I;
      w_d.val_s        = M_VAL_S_I;
      w_d.val_e        = M_VAL_E_I;
      w_d.val_m        = M_VAL_M_I;
    end
  end

  // W pipeline register.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) w_q <= '0;
    else         w_q <= w_d;
  end

  // Commit decode. Writes aimed at M (memory operand) are dropped silently.
  always_comb begin
    commit    = w_q.valid & ~STALL_I;
    wr_target = commit & w_q.dstr_cs & (w_q.dst != REG_M);
    wr_en     = wr_target & (|w_q.sel);
    sel_bad   = wr_target & ~sel_onehot(w_q.sel);
    wr_data   = sel_mux(w_q.sel, w_q.val_c, w_q.val_s, w_q.val_e, w_q.val_m);
  end

  // Retire counter, wraps naturally.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I)     retire_cnt <= '0;
    else if (commit) retire_cnt <= retire_cnt + 1'b1;
  end

  // Sticky select error, cleared only by reset.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I)      sel_err <= 1'b0;
    else if (sel_bad) sel_err <= 1'b1;
  end

  cpu_regfile #(
    .REG_NUM (REG_NUM)
  ) u_regfile (
    .clk     (CLK_I),
    .rst_n   (RSTN_I),
    .wr_en   (wr_en),
    .wr_idx  (w_q.dst),
    .wr_data (wr_data),
    .rd_idx  (REG_SRC_I),
    .rd_data (REG_BANK_O)
  );

  assign W_VAL_C_O     = w_q.val_c;
  assign W_VAL_S_O     = w_q.val_s;
  assign W_VAL_E_O     = w_q.val_e;
  assign W_VAL_M_O     = w_q.val_m;
  assign W_DST_O       = w_q.dst;
  assign W_VALID_O     = w_q.valid;
  assign W_DSTR_CS_O   = w_q.dstr_cs;
  assign W_DSTR_CS_C_O = w_q.sel[SEL_C];
  assign W_DSTR_CS_S_O = w_q.sel[SEL_S];
  assign W_DSTR_CS_E_O = w_q.sel[SEL_E];
  assign W_DSTR_CS_M_O = w_q.sel[SEL_M];
  assign RETIRE_CNT_O  = retire_cnt;
  assign SEL_ERR_O     = sel_err;

endmodule

// File: tb/tb_cpu_writeback.sv
// Directed bench for cpu_writeback with hand-computed expectations.
module tb_cpu_writeback;

  logic       CLK_I;
  logic       RSTN_I;
  logic       STALL_I;
  logic       BUBBLE_I;
  logic [7:0] M_VAL_C_I, M_VAL_S_I, M_VAL_E_I, M_VAL_M_I;
  logic [2:0] M_DST_I;
  logic       M_VALID_I, M_DSTR_CS_I;
  logic       M_DSTR_CS_C_I, M_DSTR_CS_S_I, M_DSTR_CS_E_I, M_DSTR_CS_M_I;
  logic [7:0] W_VAL_C_O, W_VAL_S_O, W_VAL_E_O, W_VAL_M_O;
  logic [2:0] W_DST_O;
  logic       W_VALID_O, W_DSTR_CS_O;
  logic       W_DSTR_CS_C_O, W_DSTR_CS_S_O, W_DSTR_CS_E_O, W_DSTR_CS_M_O;
  logic [2:0] REG_SRC_I;
  logic [7:0] REG_BANK_O;
  logic [15:0] RETIRE_CNT_O;
  logic       SEL_ERR_O;

  int n_chk  = 0;
  int n_fail = 0;

  cpu_writeback #(.REG_NUM(7), .CNT_W(16)) dut (
    .CLK_I(CLK_I), .RSTN_I(RSTN_I), .STALL_I(STALL_I), .BUBBLE_I(BUBBLE_I),
    .M_VAL_C_I(M_VAL_C_I), .M_VAL_S_I(M_VAL_S_I), .M_VAL_E_I(M_VAL_E_I), .M_VAL_M_I(M_VAL_M_I),
    .M_DST_I(M_DST_I), .M_VALID_I(M_VALID_I), .M_DSTR_CS_I(M_DSTR_CS_I),
    .M_DSTR_CS_C_I(M_DSTR_CS_C_I), .M_DSTR_CS_S_I(M_DSTR_CS_S_I),
    .M_DSTR_CS_E_I(M_DSTR_CS_E_I), .M_DSTR_CS_M_I(M_DSTR_CS_M_I),
    .W_VAL_C_O(W_VAL_C_O), .W_VAL_S_O(W_VAL_S_O), .W_VAL_E_O(W_VAL_E_O), .W_VAL_M_O(W_VAL_M_O),
    .W_DST_O(W_DST_O), .W_VALID_O(W_VALID_O), .W_DSTR_CS_O(W_DSTR_CS_O),
    .W_DSTR_CS_C_O(W_DSTR_CS_C_O), .W_DSTR_CS_S_O(W_DSTR_CS_S_O),
    .W_DSTR_CS_E_O(W_DSTR_CS_E_O), .W_DSTR_CS_M_O(W_DSTR_CS_M_O),
    .REG_SRC_I(REG_SRC_I), .REG_BANK_O(REG_BANK_O),
    .RETIRE_CNT_O(RETIRE_CNT_O), .SEL_ERR_O(SEL_ERR_O)
  );

  initial CLK_I = 1'b0;
  always #10 CLK_I = ~CLK_I;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_I);
    #1;
  endtask

  // sel bit order: {M,E,S,C}
  task automatic set_m(input logic valid, input logic cs, input logic [3:0] sel,
                       input logic [2:0] dst, input logic [7:0] vc, input logic [7:0] vs,
                       input logic [7:0] ve, input logic [7:0] vm);
    M_VALID_I     = valid;
    M_DSTR_CS_I   = cs;
    M_DSTR_CS_C_I = sel[0];
    M_DSTR_CS_S_I = sel[1];
    M_DSTR_CS_E_I = sel[2];
    M_DSTR_CS_M_I = sel[3];
    M_DST_I       = dst;
    M_VAL_C_I     = vc;
    M_VAL_S_I     = vs;
    M_VAL_E_I     = ve;
    M_VAL_M_I     = vm;
  endtask

  task automatic set_idle();
    set_m(1'b0, 1'b0, 4'b0000, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] idx, input logic [7:0] exp);
    REG_SRC_I = idx;
    #1;
    chk(tag, 32'(REG_BANK_O), 32'(exp));
  endtask

  task automatic do_reset();
    RSTN_I = 1'b0;
    step();
    step();
    RSTN_I = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_w_valid"}, 32'(W_VALID_O), 0);
    chk({tag, "_w_cs"}, 32'({W_DSTR_CS_O, W_DSTR_CS_C_O, W_DSTR_CS_S_O, W_DSTR_CS_E_O, W_DSTR_CS_M_O}), 0);
    chk({tag, "_w_dst"}, 32'(W_DST_O), 0);
    chk({tag, "_w_vals"}, {W_VAL_C_O, W_VAL_S_O, W_VAL_E_O, W_VAL_M_O}, 0);
    chk({tag, "_cnt"}, 32'(RETIRE_CNT_O), 0);
    chk({tag, "_err"}, 32'(SEL_ERR_O), 0);
  endtask

  logic [7:0] exp_regs [7];

  initial begin
    RSTN_I = 1'b0; STALL_I = 1'b0; BUBBLE_I = 1'b0; REG_SRC_I = 3'd0;
    set_idle();
    #2;
    chk_all_zero("reset");
    chk_reg("reset_reg_a", 3'd0, 8'h00);
    step();
    RSTN_I = 1'b1;

    // Basic commit through E select into C.
    set_m(1'b1, 1'b1, 4'b0100, 3'd2, 8'h00, 8'h00, 8'h5A, 8'h00);
    step();
    set_idle();
    chk("t1_w_valid", 32'(W_VALID_O), 1);
    chk("t1_w_dst", 32'(W_DST_O), 2);
    chk("t1_w_val_e", 32'(W_VAL_E_O), 'h5A);
    chk("t1_w_cs_e", 32'(W_DSTR_CS_E_O), 1);
    chk("t1_cnt_pre", 32'(RETIRE_CNT_O), 0);
    chk_reg("t1_no_writethrough", 3'd2, 8'h00);
    step();
    chk_reg("t1_reg_c", 3'd2, 8'h5A);
    chk("t1_cnt", 32'(RETIRE_CNT_O), 1);
    chk("t1_w_valid_after", 32'(W_VALID_O), 0);

    // Stall holds W for three cycles, bubble ignored while stalled.
    do_reset();
    set_m(1'b1, 1'b1, 4'b0100, 3'd2, 8'h00, 8'h00, 8'h5A, 8'h00);
    step();
    set_idle();
    STALL_I = 1'b1; BUBBLE_I = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_valid", 32'(W_VALID_O), 1);
      chk("t2_hold_val_e", 32'(W_VAL_E_O), 'h5A);
      chk("t2_hold_cs_e", 32'(W_DSTR_CS_E_O), 1);
      chk("t2_hold_cnt", 32'(RETIRE_CNT_O), 0);
      chk_reg("t2_hold_reg_c", 3'd2, 8'h00);
    end
    STALL_I = 1'b0; BUBBLE_I = 1'b0;
    step();
    chk("t2_cnt", 32'(RETIRE_CNT_O), 1);
    chk_reg("t2_reg_c", 3'd2, 8'h5A);
    step();
    chk("t2_cnt_once", 32'(RETIRE_CNT_O), 1);

    // Bubble squashes a valid M bundle; data still loads.
    set_m(1'b1, 1'b1, 4'b0001, 3'd1, 8'hFF, 8'h00, 8'h00, 8'h00);
    BUBBLE_I = 1'b1;
    step();
    BUBBLE_I = 1'b0;
    set_idle();
    chk("t3_w_valid", 32'(W_VALID_O), 0);
    chk("t3_w_cs", 32'(W_DSTR_CS_O), 0);
    chk("t3_w_cs_c", 32'(W_DSTR_CS_C_O), 0);
    chk("t3_w_val_c", 32'(W_VAL_C_O), 'hFF);
    chk("t3_w_dst", 32'(W_DST_O), 1);
    step();
    chk_reg("t3_reg_b", 3'd1, 8'h00);
    chk("t3_cnt", 32'(RETIRE_CNT_O), 1);

    // Destination M: counted, nothing written, no error.
    set_m(1'b1, 1'b1, 4'b1000, 3'd7, 8'h00, 8'h00, 8'h00, 8'h33);
    step();
    set_idle();
    chk("t4_w_dst", 32'(W_DST_O), 7);
    step();
    chk("t4_cnt", 32'(RETIRE_CNT_O), 2);
    chk("t4_err", 32'(SEL_ERR_O), 0);
    chk_reg("t4_reg_m", 3'd7, 8'h00);
    exp_regs = '{8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 7; i++) chk_reg("t4_regs", 3'(i), exp_regs[i]);

    // Two selects: M wins, error goes sticky.
    set_m(1'b1, 1'b1, 4'b1001, 3'd0, 8'h11, 8'h00, 8'h00, 8'h22);
    step();
    set_idle();
    chk("t5_err_pre", 32'(SEL_ERR_O), 0);
    step();
    chk_reg("t5_reg_a", 3'd0, 8'h22);
    chk("t5_err", 32'(SEL_ERR_O), 1);
    chk("t5_cnt", 32'(RETIRE_CNT_O), 3);
    set_m(1'b1, 1'b1, 4'b0110, 3'd4, 8'h00, 8'h66, 8'h77, 8'h00);
    step();
    set_idle();
    step();
    chk_reg("t5_reg_e_prio", 3'd4, 8'h77);
    chk("t5_cnt2", 32'(RETIRE_CNT_O), 4);
    for (int i = 0; i < 5; i++) step();
    chk("t5_err_sticky", 32'(SEL_ERR_O), 1);

    // No select set: flagged, nothing written.
    do_reset();
    #1;
    chk("t6_err_cleared", 32'(SEL_ERR_O), 0);
    set_m(1'b1, 1'b1, 4'b0000, 3'd5, 8'h99, 8'h99, 8'h99, 8'h99);
    step();
    set_idle();
    step();
    chk_reg("t6_reg_h", 3'd5, 8'h00);
    chk("t6_err", 32'(SEL_ERR_O), 1);
    chk("t6_cnt", 32'(RETIRE_CNT_O), 1);

    // Counter wrap: 65536 edges with a valid bundle held -> 65535 commits.
    do_reset();
    set_m(1'b1, 1'b1, 4'b0011, 3'd3, 8'h44, 8'h55, 8'h00, 8'h00);
    for (int i = 0; i < 65536; i++) step();
    chk("t7_cnt_max", 32'(RETIRE_CNT_O), 'hFFFF);
    chk_reg("t7_reg_d", 3'd3, 8'h55);
    chk("t7_err", 32'(SEL_ERR_O), 1);
    step();
    chk("t7_cnt_wrap", 32'(RETIRE_CNT_O), 0);
    chk("t7_w_valid", 32'(W_VALID_O), 1);

    // Asynchronous reset mid-cycle while stalled.
    STALL_I = 1'b1;
    #4;
    RSTN_I = 1'b0;
    #1;
    chk_all_zero("t8_async");
    chk_reg("t8_reg_d", 3'd3, 8'h00);
    step();
    set_idle();
    STALL_I = 1'b0;
    RSTN_I = 1'b1;
    step();
    chk("t8_cnt_discard", 32'(RETIRE_CNT_O), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_writeback.md
Name: cpu_writeback

Overview:
- Write-back (W) stage of the MCS8 pipelined core.
- Captures the M-stage result bundle into the W pipeline register and drives the W_* result and destination-control bundle that the forwarding unit consumes.
- Commits the selected result into the 7-entry register file (A,B,C,D,E,H,L) and counts retired instructions.
- Provides the raw (un-forwarded) register read port that feeds the forwarding unit's bank input.

Parameters:
- REG_NUM, 7, number of architectural registers; index 7 (M) is the memory operand and is never written here.
- CNT_W, 16, width of the retire counter.

Ports:
- CLK_I  input  1  core clock, rising edge.
- RSTN_I  input  1  asynchronous active-low reset.
- STALL_I  input  1  hold W register; no commit this cycle.
- BUBBLE_I  input  1  load an invalid slot instead of the M bundle.
- M_VAL_C_I / M_VAL_S_I / M_VAL_E_I / M_VAL_M_I  input  8 each  M-stage candidate results (M_VAL_M_I is memory read data).
- M_DST_I  input  3  destination register index.
- M_VALID_I  input  1  M slot holds a real instruction.
- M_DSTR_CS_I  input  1  instruction writes a register.
- M_DSTR_CS_C_I / _S_I / _E_I / _M_I  input  1 each  result source select.
- W_VAL_C_O / W_VAL_S_O / W_VAL_E_O / W_VAL_M_O  output  8 each  registered results.
- W_DST_O  output  3  registered destination index.
- W_VALID_O  output  1  registered valid.
- W_DSTR_CS_O, W_DSTR_CS_C_O / _S_O / _E_O / _M_O  output  1 each  registered selects.
- REG_SRC_I  input  3  read-port index.
- REG_BANK_O  output  8  read-port data.
- RETIRE_CNT_O  output  CNT_W  count of committed valid instructions.
- SEL_ERR_O  output  1  sticky: a committing instruction had zero or more than one source select set.

Behaviour:
- Reset (async, RSTN_I low): all W_* outputs 0, register file 0, RETIRE_CNT_O 0, SEL_ERR_O 0. Deassertion takes effect at the next clock edge.
- Commit condition: commit = W_VALID_O & ~STALL_I.
- On each rising edge with commit:
  - RETIRE_CNT_O increments by 1, wrapping from all-ones to 0.
  - If W_DSTR_CS_O is set and W_DST_O != 7, regfile[W_DST_O] <= selected value.
  - Selection priority: M > E > S > C.
  - If the select vector is not one-hot: SEL_ERR_O <= 1, and the register is still written per priority. If no select bit is set, no write occurs and the error is flagged.
  - W_DST_O == 7 with W_DSTR_CS_O set: no write and no error.
- W register load on each rising edge:
  - STALL_I = 1: hold all W_* outputs. BUBBLE_I is ignored.
  - STALL_I = 0: load the M bundle. W_VALID_O <= M_VALID_I & ~BUBBLE_I. When the loaded valid is 0, W_DSTR_CS_O and all four selects load 0. Data and DST fields always load.
- Latency:
  - The M bundle appears on W_* 1 cycle after it is presented.
  - The register write is visible on REG_BANK_O 1 cycle after W commits, 2 cycles after M.
- Read port:
  - Combinational: REG_BANK_O = regfile[REG_SRC_I]; index 7 returns 8'h00.
  - No write-through: a same-cycle read of the register being committed returns the old value. The forwarding unit covers that case via the W bundle.
- Simultaneous stall and valid: neither commit nor count happens; the instruction commits exactly once, when the stall drops.
- Reset mid-stall: reset wins; the pending W instruction is discarded and not counted.
- SEL_ERR_O clears only on reset.

Decomposition:
- Shared package cpu_pkg:
  - register index constants REG_A=0, REG_B=1, REG_C=2, REG_D=3, REG_E=4, REG_H=5, REG_L=6, REG_M=7;
  - select bit positions C/S/E/M;
  - DATA_W=8, REG_IDX_W=3.
- One natural sub-module: cpu_regfile (7x8 storage, one async-read port, one sync-write port with enable, async reset). The pipeline register, select mux, counter and error logic stay in cpu_writeback.

Test Plan:
- Reset then M bundle {VALID=1, CS=1, CS_E=1, DST=2, VAL_E=8'h5A}, no stall. Required: W_VALID_O=1 on the next cycle; the cycle after, REG_SRC_I=2 gives REG_BANK_O=8'h5A and RETIRE_CNT_O=1.
- Same instruction with STALL_I held 3 cycles. Required: W_* held, RETIRE_CNT_O stays 0 while stalled; after release it commits once, so count=1 and C=8'h5A.
- BUBBLE_I=1 with a valid M bundle (DST=1, CS_C=1, VAL_C=8'hFF). Required: W_VALID_O=0, W_DSTR_CS_O=0, register B unchanged (8'h00), count unchanged.
- DST=7, CS=1, CS_M=1, VAL_M=8'h33. Required: no register changes, count increments, SEL_ERR_O stays 0, REG_SRC_I=7 gives 8'h00.
- CS_C=1 and CS_M=1 together, DST=0, VAL_C=8'h11, VAL_M=8'h22. Required: A=8'h22, SEL_ERR_O=1 and sticky until reset.
- Preload the counter to 16'hFFFF by forcing it or by a long run, then commit one more. Required: RETIRE_CNT_O=0. Then assert RSTN_I=0 asynchronously mid-cycle. Required: all outputs 0 immediately, without waiting for a clock edge.
